// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral fronting a small control register file.
// Supports writes and CIPO read-back; all pins oversampled on clk.
module spi_regfile_peripheral #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SCLK,
  input  logic                       COPI,
  input  logic                       nCS,
  output logic                       CIPO,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CW    = $clog2(FRAME + 1);
  localparam int RXW   = ADDR_W + DATA_W;
  localparam logic [CW-1:0]     CNT_FULL = CW'(FRAME);
  localparam logic [CW-1:0]     CNT_LADR = CW'(ADDR_W);
  localparam logic [CW-1:0]     CNT_DATA = CW'(ADDR_W + 1);
  localparam logic [ADDR_W:0]   NREG     = (ADDR_W+1)'(NUM_REGS);

  logic [SYNC_STAGES-1:0] sclk_q, copi_q, ncs_q;
  logic                   sclk_p_q, ncs_p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q   <= '0;
      copi_q   <= '0;
      ncs_q    <= '1;
      sclk_p_q <= 1'b0;
      ncs_p_q  <= 1'b1;
    end else begin
      sclk_q   <= {sclk_q[SYNC_STAGES-2:0], SCLK};
      copi_q   <= {copi_q[SYNC_STAGES-2:0], COPI};
      ncs_q    <= {ncs_q[SYNC_STAGES-2:0], nCS};
      sclk_p_q <= sclk_q[SYNC_STAGES-1];
      ncs_p_q  <= ncs_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign copi_s    = copi_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_p_q;
  assign sclk_fall = ~sclk_s & sclk_p_q;
  assign cs_fall   = ~ncs_s & ncs_p_q;
  assign cs_rise   = ncs_s & ~ncs_p_q;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RXW-1:0]    rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wp_q, wp_d;
  logic              ferr_q, ferr_d;
  logic [ADDR_W-1:0] wa_q, wa_d;

  logic [ADDR_W-1:0] rx_addr, ld_addr;
  logic [DATA_W-1:0] rx_data, tx_load;
  logic              addr_ok;

  assign rx_addr = rx_q[DATA_W +: ADDR_W];
  assign rx_data = rx_q[DATA_W-1:0];
  // Address is complete only after the bit arriving on this rising edge.
  assign ld_addr = {rx_q[ADDR_W-2:0], copi_s};
  assign addr_ok = {1'b0, rx_addr} < NREG;

  always_comb begin
    tx_load = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ld_addr == ADDR_W'(i)) tx_load = regs_q[i];
  end

  always_comb begin
    cnt_d  = cnt_q;
    rx_d   = rx_q;
    tx_d   = tx_q;
    rw_d   = rw_q;
    regs_d = regs_q;
    wa_d   = wa_q;
    wp_d   = 1'b0;
    ferr_d = 1'b0;
    if (cs_fall) begin
      cnt_d = '0;
      rx_d  = '0;
      tx_d  = '0;
      rw_d  = 1'b0;
    end else begin
      if (!ncs_s && sclk_rise && cnt_q != CNT_FULL) begin
        if (cnt_q == '0) rw_d = copi_s;
        else             rx_d = {rx_q[RXW-2:0], copi_s};
        if (cnt_q == CNT_LADR && !rw_q) tx_d = tx_load;
        cnt_d = cnt_q + CW'(1);
      end
      if (!ncs_s && sclk_fall && cnt_q > CNT_DATA)
        tx_d = {tx_q[DATA_W-2:0], 1'b0};
      if (cs_rise) begin
        if (cnt_q == CNT_FULL && rw_q) begin
          if (addr_ok) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (rx_addr == ADDR_W'(i)) regs_d[i] = rx_data;
            wp_d = 1'b1;
            wa_d = rx_addr;
          end else begin
            ferr_d = 1'b1;
          end
        end else if (cnt_q != '0 && cnt_q != CNT_FULL) begin
          ferr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rx_q   <= '0;
      tx_q   <= '0;
      rw_q   <= 1'b0;
      wp_q   <= 1'b0;
      ferr_q <= 1'b0;
      wa_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      rw_q   <= rw_d;
      wp_q   <= wp_d;
      ferr_q <= ferr_d;
      wa_q   <= wa_d;
      regs_q <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign CIPO      = ~ncs_s & tx_q[DATA_W-1];
  assign wr_pulse  = wp_q;
  assign wr_addr   = wa_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral: default and 16x16 builds.
// Shares SCLK/COPI between both instances, separate chip selects.
module tb_spi_regfile_peripheral;

  logic clk = 1'b0;
  logic rst_n;
  logic sclk, copi, ncs1, ncs2;

  logic         cipo1, wp1, fe1;
  logic [39:0]  regs1;
  logic [6:0]   wa1;
  logic         cipo2, wp2, fe2;
  logic [255:0] regs2;
  logic [6:0]   wa2;

  int checks = 0;
  int errors = 0;
  int wp_cnt, fe_cnt, wp2_cnt, fe2_cnt;
  logic [6:0]   last_wa;
  logic [39:0]  regs_at_wp;
  logic [31:0]  miso;

  always #5 clk = ~clk;

  spi_regfile_peripheral u_dut (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk), .COPI(copi), .nCS(ncs1),
    .CIPO(cipo1), .regs_out(regs1), .wr_pulse(wp1), .wr_addr(wa1),
    .frame_err(fe1)
  );

  spi_regfile_peripheral #(.NUM_REGS(16), .DATA_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk), .COPI(copi), .nCS(ncs2),
    .CIPO(cipo2), .regs_out(regs2), .wr_pulse(wp2), .wr_addr(wa2),
    .frame_err(fe2)
  );

  always @(negedge clk) begin
    if (wp1) begin
      wp_cnt++;
      last_wa = wa1;
      regs_at_wp = regs1;
    end
    if (fe1) fe_cnt++;
    if (wp2) wp2_cnt++;
    if (fe2) fe2_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_cnt();
    wp_cnt = 0; fe_cnt = 0; wp2_cnt = 0; fe2_cnt = 0;
  endtask

  task automatic cs_low(input int sel);
    if (sel == 2) ncs2 = 1'b0; else ncs1 = 1'b0;
    wclk(8);
  endtask

  task automatic cs_high();
    wclk(8);
    ncs1 = 1'b1;
    ncs2 = 1'b1;
    wclk(12);
  endtask

  task automatic spi_bits(input int sel, input logic [31:0] bits,
                          input int n);
    miso = '0;
    for (int i = 0; i < n; i++) begin
      copi = bits[n-1-i];
      wclk(8);
      sclk = 1'b1;
      miso = {miso[30:0], (sel == 2) ? cipo2 : cipo1};
      wclk(8);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input int sel, input logic [31:0] bits,
                       input int n);
    cs_low(sel);
    spi_bits(sel, bits, n);
    cs_high();
  endtask

  initial begin
    rst_n = 1'b0;
    sclk = 1'b0; copi = 1'b0; ncs1 = 1'b1; ncs2 = 1'b1;
    clr_cnt();
    last_wa = '0;
    regs_at_wp = '0;
    wclk(5);
    check("rst_regs", {24'd0, regs1}, 64'd0);
    check("rst_out", {cipo1, wp1, fe1, wa1}, 64'd0);
    rst_n = 1'b1;
    wclk(5);

    clr_cnt();
    frame(1, {16'd0, 1'b1, 7'd4, 8'hA5}, 16);
    check("wr4_reg", {56'd0, regs1[39:32]}, 64'hA5);
    check("wr4_pulse", wp_cnt, 1);
    check("wr4_addr", {57'd0, last_wa}, 4);
    check("wr4_same_cyc", {56'd0, regs_at_wp[39:32]}, 64'hA5);
    check("wr4_noerr", fe_cnt, 0);

    clr_cnt();
    frame(1, {16'd0, 1'b0, 7'd4, 8'h00}, 16);
    check("rd4_cipo", {56'd0, miso[7:0]}, 64'hA5);
    check("rd4_nomod", {24'd0, regs1}, {24'd0, 8'hA5, 32'd0});
    check("rd4_nopulse", wp_cnt + fe_cnt, 0);

    clr_cnt();
    frame(1, {16'd0, 1'b1, 7'd7, 8'hFF}, 16);
    check("wr7_regs", {24'd0, regs1}, {24'd0, 8'hA5, 32'd0});
    check("wr7_err", fe_cnt, 1);
    check("wr7_nowp", wp_cnt, 0);

    clr_cnt();
    frame(1, {22'd0, 1'b1, 7'd1, 2'b00}, 10);
    check("trunc_err", fe_cnt, 1);
    check("trunc_nowp", wp_cnt, 0);
    frame(1, {16'd0, 1'b1, 7'd1, 8'h3C}, 16);
    check("wr1_reg", {56'd0, regs1[15:8]}, 64'h3C);
    check("wr1_pulse", wp_cnt, 1);
    check("wr1_addr", {57'd0, last_wa}, 1);

    clr_cnt();
    frame(1, {16'd0, 1'b0, 7'd6, 8'h00}, 16);
    check("rd6_cipo", {32'd0, miso}, 64'd0);
    check("rd6_noerr", fe_cnt, 0);

    clr_cnt();
    frame(1, {12'd0, 1'b1, 7'd0, 8'h81, 4'hF}, 20);
    check("long_reg0", {56'd0, regs1[7:0]}, 64'h81);
    check("long_pulse", wp_cnt, 1);
    check("long_noerr", fe_cnt, 0);

    clr_cnt();
    cs_low(1);
    spi_bits(1, {22'd0, 1'b1, 7'd2, 2'b11}, 10);
    rst_n = 1'b0;
    wclk(2);
    ncs1 = 1'b1;
    wclk(3);
    rst_n = 1'b1;
    wclk(20);
    check("rst_mid_regs", {24'd0, regs1}, 64'd0);
    check("rst_mid_nowp", wp_cnt, 0);
    check("rst_mid_noerr", fe_cnt, 0);

    clr_cnt();
    frame(2, {8'd0, 1'b1, 7'd15, 16'hBEEF}, 24);
    check("w16_reg", {48'd0, regs2[255:240]}, 64'hBEEF);
    check("w16_pulse", wp2_cnt, 1);
    check("w16_addr", {57'd0, wa2}, 15);
    frame(2, {8'd0, 1'b0, 7'd15, 16'h0000}, 24);
    check("r16_cipo", {48'd0, miso[15:0]}, 64'hBEEF);
    check("d1_untouched", {24'd0, regs1}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
